// File: rtl/spi_xfer_sched_pkg.sv
// Shared definitions for the SPI transfer scheduler: default widths, state
// encoding and small helpers used by the top and its arbiter.
package spi_xfer_sched_pkg;

    localparam int SPI_W_CPU   = 32;
    localparam int SPI_TIMEOUT = 1024;
    localparam int SPI_W_TO    = 11;

    typedef enum logic [1:0] {
        SPIS_IDLE    = 2'd0,
        SPIS_LAUNCH  = 2'd1,
        SPIS_WAIT_RX = 2'd2,
        SPIS_RESP    = 2'd3
    } spis_e;

    // One-hot strobe vector for the port that owns the transfer.
    function automatic logic [1:0] port_onehot(input logic idx);
        logic [1:0] vec;
        if (idx) begin
            vec = 2'b10;
        end else begin
            vec = 2'b01;
        end
        return vec;
    endfunction

endpackage

// File: rtl/spi_xfer_sched_rr_arb2.sv
// Two-way round-robin picker: on a tie the port that did not win last time
// is chosen, otherwise the single requesting port.
module spi_xfer_sched_rr_arb2
    import spi_xfer_sched_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt,
    output logic       any
);

    // Grant selection; gnt is meaningless when any is low.
    always_comb begin
        gnt = 1'b0;
        any = |req;
        if (req == 2'b11) begin
            gnt = ~last_grant;
        end else if (req[1]) begin
            gnt = 1'b1;
        end else begin
            gnt = 1'b0;
        end
    end

endmodule

// File: rtl/spi_xfer_sched.sv
// Arbitrates two word-level requesters onto one SPI engine and returns each
// received word (or a timeout error) to the requester that launched it.
module spi_xfer_sched
    import spi_xfer_sched_pkg::*;
#(
    parameter int W_CPU   = SPI_W_CPU,
    parameter int TIMEOUT = SPI_TIMEOUT,
    parameter int W_TO    = SPI_W_TO
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [W_CPU-1:0] req0_wdata,
    output logic             req0_ready,
    output logic             rsp0_valid,
    output logic [W_CPU-1:0] rsp0_rdata,
    output logic             rsp0_err,
    input  logic             req1_valid,
    input  logic [W_CPU-1:0] req1_wdata,
    output logic             req1_ready,
    output logic             rsp1_valid,
    output logic [W_CPU-1:0] rsp1_rdata,
    output logic             rsp1_err,
    input  logic             spi_tx_ready,
    output logic [W_CPU-1:0] spi_tx_data,
    output logic             spi_tx_valid,
    input  logic [W_CPU-1:0] spi_rx_data,
    input  logic             spi_rx_valid,
    output logic             busy,
    output logic             owner
);

    localparam logic [W_TO-1:0] TO_LAST = W_TO'(TIMEOUT - 1);
    localparam logic [W_TO-1:0] TO_ONE  = W_TO'(1);

    spis_e                     state_q, state_d;
    logic                      last_grant_q, last_grant_d;
    logic [W_TO-1:0]           cnt_q, cnt_d;
    logic [W_CPU-1:0]          tx_data_q, tx_data_d;
    logic                      tx_valid_q, tx_valid_d;
    logic                      owner_q, owner_d;
    logic                      busy_q, busy_d;
    logic [1:0]                rsp_valid_q, rsp_valid_d;
    logic [1:0]                rsp_err_q, rsp_err_d;
    logic [1:0][W_CPU-1:0]     rsp_rdata_q, rsp_rdata_d;

    logic                      gnt_s;
    logic                      any_s;
    logic                      accept_s;

    spi_xfer_sched_rr_arb2 u_arb (
        .req        ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .gnt        (gnt_s),
        .any        (any_s)
    );

    // Request acceptance is combinational so a requester sees ready in the
    // same cycle it is granted; the engine's ready only matters while idle.
    always_comb begin
        accept_s   = (state_q == SPIS_IDLE) & spi_tx_ready & any_s;
        req0_ready = accept_s & ~gnt_s;
        req1_ready = accept_s & gnt_s;
    end

    // Next-state and next-output computation for the transfer sequencer.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = 1'b0;
        owner_d      = owner_q;
        rsp_valid_d  = 2'b00;
        rsp_err_d    = 2'b00;
        rsp_rdata_d  = rsp_rdata_q;
        case (state_q)
            SPIS_IDLE: begin
                if (accept_s) begin
                    if (gnt_s) begin
                        tx_data_d = req1_wdata;
                    end else begin
                        tx_data_d = req0_wdata;
                    end
                    owner_d      = gnt_s;
                    last_grant_d = gnt_s;
                    tx_valid_d   = 1'b1;
                    state_d      = SPIS_LAUNCH;
                end else begin
                    state_d = SPIS_IDLE;
                end
            end
            SPIS_LAUNCH: begin
                cnt_d   = {W_TO{1'b0}};
                state_d = SPIS_WAIT_RX;
            end
            SPIS_WAIT_RX: begin
                cnt_d = cnt_q + TO_ONE;
                // Received data takes priority over an expiry in the same cycle.
                if (spi_rx_valid) begin
                    rsp_rdata_d[owner_q] = spi_rx_data;
                    rsp_valid_d          = port_onehot(owner_q);
                    state_d              = SPIS_RESP;
                end else if (cnt_q == TO_LAST) begin
                    rsp_rdata_d[owner_q] = {W_CPU{1'b0}};
                    rsp_valid_d          = port_onehot(owner_q);
                    rsp_err_d            = port_onehot(owner_q);
                    state_d              = SPIS_RESP;
                end else begin
                    state_d = SPIS_WAIT_RX;
                end
            end
            SPIS_RESP: begin
                state_d = SPIS_IDLE;
            end
            default: begin
                state_d = SPIS_IDLE;
            end
        endcase
        busy_d = (state_d != SPIS_IDLE);
    end

    // State and registered outputs; reset drops any transfer in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= SPIS_IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= {W_TO{1'b0}};
            tx_data_q    <= {W_CPU{1'b0}};
            tx_valid_q   <= 1'b0;
            owner_q      <= 1'b0;
            busy_q       <= 1'b0;
            rsp_valid_q  <= 2'b00;
            rsp_err_q    <= 2'b00;
            rsp_rdata_q  <= {2{{W_CPU{1'b0}}}};
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            owner_q      <= owner_d;
            busy_q       <= busy_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    // Port-level view of the registered state.
    always_comb begin
        spi_tx_data  = tx_data_q;
        spi_tx_valid = tx_valid_q;
        busy         = busy_q;
        owner        = owner_q;
        rsp0_valid   = rsp_valid_q[0];
        rsp1_valid   = rsp_valid_q[1];
        rsp0_err     = rsp_err_q[0];
        rsp1_err     = rsp_err_q[1];
        rsp0_rdata   = rsp_rdata_q[0];
        rsp1_rdata   = rsp_rdata_q[1];
    end

endmodule

// File: tb/tb_spi_xfer_sched.sv
// Randomized self-checking bench for spi_xfer_sched against a transaction-level
// model (round-robin winner, launch/response cycle arithmetic, held read data).
module tb_spi_xfer_sched;

    localparam int TIMEOUT = 16;
    localparam int W_TO    = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0] req0_wdata = 32'h0, req1_wdata = 32'h0;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic        spi_tx_ready = 1'b0;
    logic [31:0] spi_tx_data;
    logic        spi_tx_valid;
    logic [31:0] spi_rx_data = 32'h0;
    logic        spi_rx_valid = 1'b0;
    logic        busy, owner;

    int          checks   = 0;
    int          failures = 0;
    bit          last_m   = 1'b1;
    logic [31:0] rdata_m [2] = '{32'h0, 32'h0};

    spi_xfer_sched #(.W_CPU(32), .TIMEOUT(TIMEOUT), .W_TO(W_TO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .spi_tx_ready(spi_tx_ready), .spi_tx_data(spi_tx_data), .spi_tx_valid(spi_tx_valid),
        .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_rspv"}, {30'h0, rsp1_valid, rsp0_valid}, 32'h0);
        chk({tag, "_rd0"}, rsp0_rdata, rdata_m[0]);
        chk({tag, "_rd1"}, rsp1_rdata, rdata_m[1]);
    endtask

    // One complete transfer starting from an idle scheduler.
    task automatic do_xfer(input bit v0, input bit v1, input int rdy_dly, input int rx_dly,
                           input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] rxd);
        int          win;
        int          fin;
        bit          exp_err;
        logic [31:0] exp_w;
        win   = (v0 && v1) ? (last_m ? 0 : 1) : (v0 ? 0 : 1);
        exp_w = (win == 1) ? w1 : w0;
        req0_valid = v0; req1_valid = v1;
        req0_wdata = w0; req1_wdata = w1;
        for (int i = 0; i < rdy_dly; i++) begin
            spi_tx_ready = 1'b0;
            spi_rx_valid = 1'($urandom_range(0, 1));
            spi_rx_data  = $urandom;
            @(negedge clk);
            chk("nordy_r0", req0_ready, 32'h0);
            chk("nordy_r1", req1_ready, 32'h0);
            chk("nordy_txv", spi_tx_valid, 32'h0);
            chk("nordy_busy", busy, 32'h0);
            chk_quiet("nordy");
            next_cyc();
        end
        spi_tx_ready = 1'b1;
        spi_rx_valid = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("acc_r0", req0_ready, 32'(win == 0));
        chk("acc_r1", req1_ready, 32'(win == 1));
        next_cyc();
        // Launch cycle: wdata changes and stray rx strobes must be ignored.
        req0_wdata   = $urandom;
        req1_wdata   = $urandom;
        spi_tx_ready = 1'($urandom_range(0, 1));
        spi_rx_valid = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("launch_txv", spi_tx_valid, 32'h1);
        chk("launch_txd", spi_tx_data, exp_w);
        chk("launch_owner", owner, 32'(win));
        chk("launch_busy", busy, 32'h1);
        chk_quiet("launch");
        next_cyc();
        fin = (rx_dly <= TIMEOUT) ? rx_dly : TIMEOUT;
        for (int k = 1; k <= fin; k++) begin
            spi_rx_valid = (k == rx_dly);
            spi_rx_data  = (k == rx_dly) ? rxd : $urandom;
            @(negedge clk);
            chk("wait_txv", spi_tx_valid, 32'h0);
            chk("wait_busy", busy, 32'h1);
            chk_quiet("wait");
            next_cyc();
        end
        exp_err      = (rx_dly > TIMEOUT);
        rdata_m[win] = exp_err ? 32'h0 : rxd;
        spi_rx_valid = 1'($urandom_range(0, 1));
        spi_rx_data  = $urandom;
        spi_tx_ready = 1'b0;
        @(negedge clk);
        chk("resp_v", {30'h0, rsp1_valid, rsp0_valid}, (win == 1) ? 32'h2 : 32'h1);
        chk("resp_err", (win == 1) ? rsp1_err : rsp0_err, 32'(exp_err));
        chk("resp_rd0", rsp0_rdata, rdata_m[0]);
        chk("resp_rd1", rsp1_rdata, rdata_m[1]);
        chk("resp_owner", owner, 32'(win));
        chk("resp_busy", busy, 32'h1);
        next_cyc();
        spi_rx_valid = 1'b0;
        @(negedge clk);
        chk("post_busy", busy, 32'h0);
        chk("post_r0", req0_ready, 32'h0);
        chk_quiet("post");
        last_m = (win == 1);
        next_cyc();
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 32'h0);
        chk("rst_owner", owner, 32'h0);
        chk("rst_txv", spi_tx_valid, 32'h0);
        chk("rst_txd", spi_tx_data, 32'h0);
        chk("rst_err", {30'h0, rsp1_err, rsp0_err}, 32'h0);
        chk_quiet("rst");
        next_cyc();
        rst = 1'b1;
        next_cyc();

        // Directed first transfer, then tie-breaking, engine stall, timeout edges
        do_xfer(1'b1, 1'b0, 0, 8, 32'hA5A5_0001, 32'h0, 32'h1234_5678);
        for (int i = 0; i < 4; i++) do_xfer(1'b1, 1'b1, 0, 3, 32'h11, 32'h22, $urandom);
        do_xfer(1'b0, 1'b1, 5, 4, 32'h0, $urandom, $urandom);
        do_xfer(1'b1, 1'b0, 0, TIMEOUT + 5, $urandom, 32'h0, $urandom);
        do_xfer(1'b0, 1'b1, 0, TIMEOUT, 32'h0, $urandom, 32'hCAFE_F00D);
        do_xfer(1'b1, 1'b1, 1, TIMEOUT - 1, $urandom, $urandom, $urandom);
        do_xfer(1'b1, 1'b1, 0, 1, $urandom, $urandom, $urandom);

        // Reset during WAIT_RX
        req0_valid = 1'b0; req1_valid = 1'b1; req1_wdata = 32'hDEAD_BEEF;
        spi_tx_ready = 1'b1; spi_rx_valid = 1'b0;
        @(negedge clk);
        chk("mr_acc", req1_ready, 32'h1);
        next_cyc();
        spi_tx_ready = 1'b0; req1_valid = 1'b0;
        next_cyc();
        next_cyc();
        rst = 1'b0;
        #1;
        chk("mr_busy", busy, 32'h0);
        chk("mr_owner", owner, 32'h0);
        chk("mr_txd", spi_tx_data, 32'h0);
        chk("mr_txv", spi_tx_valid, 32'h0);
        chk("mr_rd0", rsp0_rdata, 32'h0);
        chk("mr_rd1", rsp1_rdata, 32'h0);
        rdata_m[0] = 32'h0; rdata_m[1] = 32'h0; last_m = 1'b1;
        next_cyc();
        rst = 1'b1;
        spi_rx_valid = 1'b1; spi_rx_data = 32'h5555_AAAA;
        next_cyc();
        spi_rx_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("late_busy", busy, 32'h0);
            chk_quiet("late");
            next_cyc();
        end
        do_xfer(1'b1, 1'b0, 0, 2, 32'h0BAD_0001, 32'h0, $urandom);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            bit v0, v1;
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            do_xfer(v0, v1, $urandom_range(0, 3), $urandom_range(1, TIMEOUT + 3),
                    $urandom, $urandom, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
